serial_add_sub: RTL

- Bit-serial adder/subtractor built around one full-adder cell and a carry flip-flop; processes WIDTH-bit two's-complement operands LSB-first, one bit per clock.
- Sits directly downstream of the combinational adder cells and uses the same sum/carry equations: s = a^b^c, cout = ab|ac|bc.
- Trades latency for area on Basys3 designs where a ripple-carry chain is not wanted.
- Provides a start/busy/done handshake for a controlling FSM or a switch/button front-end.

---
 rtl/serial_add_sub.sv | 102 ++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell plus a carry
// flip-flop, LSB-first, one bit per clock, with a start/busy/done handshake.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  // Handshake: start is honoured only while busy=0 (IDLE or DONE), and a, b and sub
  // are captured on that accepting edge. busy then stays high for WIDTH cycles, and
  // done pulses for one cycle in the same cycle that result/cout/overflow change.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_carry;

  assign fa_sum    = sh_a[0] ^ sh_b[0] ^ carry;
  assign fa_carry  = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_r     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sh_r  <= {fa_sum, sh_r[WIDTH-1:1]};
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          carry <= fa_carry;
          if (cnt == LAST) begin
            // Here carry still holds the carry into the MSB.
            result   <= {fa_sum, sh_r[WIDTH-1:1]};
            cout     <= fa_carry;
            overflow <= carry ^ fa_carry;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
